// File: rtl/ibex_counter_pkg.sv
// Shared types and constants for the counter read path.
package ibex_counter_pkg;

    localparam int unsigned CSR_W = 32;
    localparam int unsigned CNT_W = 64;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } counter_rd_state_e;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } counter_half_e;

    // Ones in the implemented bit positions of a counter, zeros above.
    function automatic logic [CNT_W-1:0] counter_mask(input int unsigned width);
        logic [CNT_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ibex_counter_shadow.sv
// Per-counter high-half shadow: snapshot on low read, dropped on write or consume.
module ibex_counter_shadow
    import ibex_counter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             consume_i,
    input  logic [CSR_W-1:0] din_i,
    output logic [CSR_W-1:0] shadow_o,
    output logic             vld_o
);

    logic [CSR_W-1:0] r_shadow;
    logic             r_vld;

    // A software write invalidates the snapshot even if a load lands on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
            r_vld    <= 1'b0;
        end else begin
            if (load_i) r_shadow <= din_i;
            if (clear_i)        r_vld <= 1'b0;
            else if (load_i)    r_vld <= 1'b1;
            else if (consume_i) r_vld <= 1'b0;
        end
    end

    assign shadow_o = r_shadow;
    assign vld_o    = r_vld;

endmodule

// File: rtl/ibex_counter_reader.sv
// CSR read front-end for the counter bank with carry-consistent 64-bit reads.
module ibex_counter_reader
    import ibex_counter_pkg::*;
#(
    parameter  int unsigned NumCounters  = 4,
    parameter  int unsigned CounterWidth = 64,
    localparam int unsigned IdxW         = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [CNT_W*NumCounters-1:0] counters_i,
    input  logic [NumCounters-1:0]       wr_pulse_i,
    input  logic                         rd_req_i,
    input  logic [IdxW-1:0]              rd_idx_i,
    input  logic                         rd_hi_i,
    output logic                         rd_ready_o,
    output logic                         rd_valid_o,
    output logic [CSR_W-1:0]             rd_data_o,
    output logic                         rd_err_o
);

    localparam logic [CNT_W-1:0] CntMask = counter_mask(CounterWidth);

    counter_rd_state_e r_state;
    counter_rd_state_e w_state_nxt;
    counter_half_e     w_half;

    logic                                    w_accept;
    logic                                    w_in_range;
    logic [NumCounters-1:0]                  w_sel;
    logic [NumCounters-1:0]                  w_load;
    logic [NumCounters-1:0]                  w_consume;
    logic [NumCounters-1:0]                  w_vld;
    logic [NumCounters-1:0][CNT_W-1:0]       w_cnt;
    logic [NumCounters-1:0][CSR_W-1:0]       w_shadow;
    logic [CSR_W-1:0]                        w_data_nxt;
    logic [CSR_W-1:0]                        r_data;
    logic                                    r_err;

    assign w_half   = counter_half_e'(rd_hi_i);
    assign w_accept = rd_req_i && rd_ready_o;

    for (genvar k = 0; k < int'(NumCounters); k++) begin : g_cnt
        assign w_cnt[k]     = counters_i[CNT_W*k +: CNT_W] & CntMask;
        assign w_sel[k]     = (rd_idx_i == IdxW'(k));
        assign w_load[k]    = w_accept && w_sel[k] && (w_half == HALF_LO);
        assign w_consume[k] = w_accept && w_sel[k] && (w_half == HALF_HI) && w_vld[k];

        ibex_counter_shadow u_shadow (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .load_i    (w_load[k]),
            .clear_i   (wr_pulse_i[k]),
            .consume_i (w_consume[k]),
            .din_i     (w_cnt[k][CNT_W-1:CSR_W]),
            .shadow_o  (w_shadow[k]),
            .vld_o     (w_vld[k])
        );
    end

    assign w_in_range = |w_sel;

    // Response mux: high half prefers a live snapshot over the running counter.
    always_comb begin
        w_data_nxt = '0;
        for (int unsigned k = 0; k < NumCounters; k++) begin
            if (w_sel[k]) begin
                if (w_half == HALF_HI) begin
                    w_data_nxt = w_vld[k] ? w_shadow[k] : w_cnt[k][CNT_W-1:CSR_W];
                end else begin
                    w_data_nxt = w_cnt[k][CSR_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= RD_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: if (w_accept) w_state_nxt = RD_RESP;
            RD_RESP: w_state_nxt = RD_IDLE;
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_ready_o = 1'b0;
        rd_valid_o = 1'b0;
        case (r_state)
            RD_IDLE: rd_ready_o = !rst_i;
            RD_RESP: rd_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_data_nxt;
            r_err  <= !w_in_range;
        end
    end

    assign rd_data_o = r_data;
    assign rd_err_o  = r_err;

endmodule

// File: tb/tb_ibex_counter_reader.sv
// Directed bench: a 4x64-bit instance and a 3x40-bit instance driven from a vector table.
module tb_ibex_counter_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0][63:0] ctr_a;
    logic [3:0]       wr_a;
    logic             req_a, hi_a, rdy_a, vld_a, err_a;
    logic [1:0]       idx_a;
    logic [31:0]      data_a;

    logic [2:0][63:0] ctr_b;
    logic [2:0]       wr_b;
    logic             req_b, hi_b, rdy_b, vld_b, err_b;
    logic [1:0]       idx_b;
    logic [31:0]      data_b;

    ibex_counter_reader #(.NumCounters(4), .CounterWidth(64)) u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .counters_i (ctr_a),
        .wr_pulse_i (wr_a),
        .rd_req_i   (req_a),
        .rd_idx_i   (idx_a),
        .rd_hi_i    (hi_a),
        .rd_ready_o (rdy_a),
        .rd_valid_o (vld_a),
        .rd_data_o  (data_a),
        .rd_err_o   (err_a)
    );

    ibex_counter_reader #(.NumCounters(3), .CounterWidth(40)) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .counters_i (ctr_b),
        .wr_pulse_i (wr_b),
        .rd_req_i   (req_b),
        .rd_idx_i   (idx_b),
        .rd_hi_i    (hi_b),
        .rd_ready_o (rdy_b),
        .rd_valid_o (vld_b),
        .rd_data_o  (data_b),
        .rd_err_o   (err_b)
    );

    typedef struct {
        bit          use_b;
        int          set_k;
        logic [63:0] set_val;
        logic [1:0]  idx;
        bit          hi;
        bit          wr;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit use_b, input int set_k, input logic [63:0] set_val,
                                input logic [1:0] idx, input bit hi, input bit wr,
                                input logic [31:0] exp_d, input bit exp_e);
        vec_t v;
        v.use_b = use_b; v.set_k = set_k; v.set_val = set_val;
        v.idx = idx; v.hi = hi; v.wr = wr; v.exp_d = exp_d; v.exp_e = exp_e;
        return v;
    endfunction

    // One complete read: wait for ready, accept, check the single-cycle response and hold.
    task automatic do_read(input bit use_b, input logic [1:0] idx, input bit hi, input bit wr,
                           input logic [31:0] exp_d, input bit exp_e, input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(use_b ? rdy_b : rdy_a) && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 32'(use_b ? rdy_b : rdy_a), 32'd1);
        if (use_b) begin
            req_b = 1'b1; idx_b = idx; hi_b = hi; wr_b = wr ? 3'(1 << idx) : 3'b0;
        end else begin
            req_a = 1'b1; idx_a = idx; hi_a = hi; wr_a = wr ? 4'(1 << idx) : 4'b0;
        end
        @(negedge clk);
        req_a = 1'b0; wr_a = '0; req_b = 1'b0; wr_b = '0;
        chk({tag, " valid"}, 32'(use_b ? vld_b : vld_a), 32'd1);
        chk({tag, " data"}, use_b ? data_b : data_a, exp_d);
        chk({tag, " err"}, 32'(use_b ? err_b : err_a), 32'(exp_e));
        chk({tag, " busy"}, 32'(use_b ? rdy_b : rdy_a), 32'd0);
        @(negedge clk);
        chk({tag, " valid_drop"}, 32'(use_b ? vld_b : vld_a), 32'd0);
        chk({tag, " data_hold"}, use_b ? data_b : data_a, exp_d);
    endtask

    vec_t vecs[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(0, 0, 64'h0000_0001_FFFF_FFFF, 2'd0, 0, 0, 32'hFFFF_FFFF, 0);
        vecs[1]  = mk(0, 0, 64'h0000_0002_0000_0000, 2'd0, 1, 0, 32'h0000_0001, 0);
        vecs[2]  = mk(0, 2, 64'hDEAD_BEEF_0000_0000, 2'd2, 1, 0, 32'hDEAD_BEEF, 0);
        vecs[3]  = mk(0, -1, 64'h0,                  2'd2, 0, 0, 32'h0000_0000, 0);
        vecs[4]  = mk(0, 2, 64'h1234_5678_0000_0005, 2'd2, 1, 0, 32'hDEAD_BEEF, 0);
        vecs[5]  = mk(0, -1, 64'h0,                  2'd2, 1, 0, 32'h1234_5678, 0);
        vecs[6]  = mk(0, 1, 64'hAAAA_0001_BBBB_0002, 2'd1, 0, 1, 32'hBBBB_0002, 0);
        vecs[7]  = mk(0, 1, 64'h5555_0000_0000_0000, 2'd1, 1, 0, 32'h5555_0000, 0);
        vecs[8]  = mk(0, 0, 64'h0000_0007_0000_0008, 2'd0, 0, 0, 32'h0000_0008, 0);
        vecs[9]  = mk(0, 3, 64'h0000_000A_0000_000B, 2'd3, 0, 0, 32'h0000_000B, 0);
        vecs[10] = mk(0, 0, 64'h0000_0009_0000_0000, 2'd0, 1, 0, 32'h0000_0007, 0);
        vecs[11] = mk(0, 0, 64'h0000_0011_0000_0001, 2'd0, 0, 0, 32'h0000_0001, 0);
        vecs[12] = mk(0, 0, 64'h0000_0022_0000_0002, 2'd0, 0, 0, 32'h0000_0002, 0);
        vecs[13] = mk(0, 0, 64'h0000_0033_0000_0000, 2'd0, 1, 0, 32'h0000_0022, 0);
        vecs[14] = mk(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 0, 0, 32'hFFFF_FFFF, 0);
        vecs[15] = mk(1, -1, 64'h0,                  2'd0, 1, 0, 32'h0000_00FF, 0);
        vecs[16] = mk(1, 1, 64'h0000_0012_0000_0034, 2'd1, 0, 0, 32'h0000_0034, 0);
        vecs[17] = mk(1, -1, 64'h0,                  2'd3, 0, 0, 32'h0000_0000, 1);
        vecs[18] = mk(1, -1, 64'h0,                  2'd3, 1, 0, 32'h0000_0000, 1);
        vecs[19] = mk(1, 1, 64'h0000_0099_0000_0000, 2'd1, 1, 0, 32'h0000_0012, 0);
        vecs[20] = mk(1, -1, 64'h0,                  2'd0, 1, 0, 32'h0000_00FF, 0);

        rst = 1'b1;
        ctr_a = '0; wr_a = '0; req_a = 1'b0; idx_a = '0; hi_a = 1'b0;
        ctr_b = '0; wr_b = '0; req_b = 1'b0; idx_b = '0; hi_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready_a", 32'(rdy_a), 32'd0);
        chk("rst ready_b", 32'(rdy_b), 32'd0);
        chk("rst valid_a", 32'(vld_a), 32'd0);
        chk("rst data_a", data_a, 32'd0);
        chk("rst err_a", 32'(err_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst ready_a", 32'(rdy_a), 32'd1);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].set_k >= 0) begin
                if (vecs[i].use_b) ctr_b[vecs[i].set_k] = vecs[i].set_val;
                else               ctr_a[vecs[i].set_k] = vecs[i].set_val;
            end
            do_read(vecs[i].use_b, vecs[i].idx, vecs[i].hi, vecs[i].wr,
                    vecs[i].exp_d, vecs[i].exp_e, $sformatf("v%0d", i));
        end

        // Reset landing on the response cycle: pulse suppressed, snapshot discarded.
        ctr_a[0] = 64'h0000_0044_0000_0001;
        @(negedge clk);
        req_a = 1'b1; idx_a = 2'd0; hi_a = 1'b0;
        @(negedge clk);
        req_a = 1'b0;
        chk("rr valid", 32'(vld_a), 32'd1);
        chk("rr data", data_a, 32'h0000_0001);
        rst = 1'b1;
        ctr_a[0] = 64'h0000_0055_0000_0000;
        @(negedge clk);
        chk("rr no_pulse", 32'(vld_a), 32'd0);
        chk("rr ready_in_rst", 32'(rdy_a), 32'd0);
        chk("rr data_cleared", data_a, 32'd0);
        chk("rr err_cleared", 32'(err_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rr ready_after", 32'(rdy_a), 32'd1);
        chk("rr valid_after", 32'(vld_a), 32'd0);
        do_read(1'b0, 2'd0, 1'b1, 1'b0, 32'h0000_0055, 1'b0, "rr_hi");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibex_counter_reader.md
# ibex_counter_reader

Read-side companion to the performance/cycle counter bank: serves 32-bit CSR reads of up to `NumCounters` 64-bit counters. Reading a low half snapshots that counter's high half into a per-counter shadow, so a following high-half read returns a carry-consistent value even if the low half wrapped in between. Sits between the CSR read mux and the counter instances, consuming their `counter_val_o` buses.

## Interface
- `NumCounters`, 4: number of counters served, 1..32.
- `CounterWidth`, 64: implemented bits per counter, 1..64; bits `[63:CounterWidth]` always read 0.
- `IdxW`, max(1, clog2(NumCounters)): derived index width; not to be overridden.

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `counters_i` in 64*NumCounters: live counter values; counter k occupies bits `[64k+63:64k]`.
- `wr_pulse_i` in NumCounters: bit k high for the cycle in which counter k is written by software.
- `rd_req_i` in 1: read request; accepted when `rd_req_i && rd_ready_o`.
- `rd_idx_i` in IdxW: counter index, sampled at accept.
- `rd_hi_i` in 1: 0 = low half `[31:0]`, 1 = high half `[63:32]`; sampled at accept.
- `rd_ready_o` out 1: block idle and able to accept.
- `rd_valid_o` out 1: one-cycle response strobe.
- `rd_data_o` out 32: response data, valid only with `rd_valid_o`.
- `rd_err_o` out 1: index ≥ NumCounters; valid only with `rd_valid_o`.

## Operation
- FSM states: IDLE, RESP. Reset and `rst_i` high force IDLE.
- IDLE: `rd_ready_o` = 1. On accept, capture response into registers, go to RESP.
- RESP: `rd_valid_o` = 1, `rd_ready_o` = 0; unconditionally return to IDLE next cycle. No back-pressure on the response.
- Low read of k: data = `counters_i[k][31:0]` as presented in the accept cycle; same edge loads shadow[k] ← `counters_i[k][63:32]` and sets shadow_vld[k].
- High read of k: if shadow_vld[k], data = shadow[k] and shadow_vld[k] is cleared; otherwise data = live `counters_i[k][63:32]`.
- Out-of-range index: data = 0, `rd_err_o` = 1; no shadow state changes.
- `wr_pulse_i[k]` clears shadow_vld[k]. Same-cycle low-read accept and `wr_pulse_i[k]`: data is the pre-write live value; the clear wins and shadow_vld[k] ends up 0.
- Low read of a different index j leaves shadow_vld[k] untouched. A repeated low read of k reloads shadow[k].
- Bits ≥ CounterWidth of each counter are forced to 0 before capture and shadowing.

## Timing
- Reset values: `rd_valid_o` 0, `rd_err_o` 0, `rd_data_o` 0, all shadow 0, all shadow_vld 0. `rd_ready_o` is 0 while `rst_i` is high and 1 in the first cycle after.
- Latency: accept at edge N, `rd_valid_o` high in cycle N+1 only. Maximum throughput is one read per 2 cycles.
- `rd_data_o` and `rd_err_o` are registered and hold their last value when `rd_valid_o` is low. They are 0 after reset.
- `rst_i` asserted during RESP: no response pulse after the reset edge; shadows cleared.
- Requests presented while `rd_ready_o` = 0 are ignored. The requester must hold them.

## Structure
- `ibex_counter_pkg` holds:
  - state enum `counter_rd_state_e` {RD_IDLE, RD_RESP};
  - half-select enum `counter_half_e` {HALF_LO, HALF_HI};
  - localparam `CSR_W` = 32.
- Sub-module `ibex_counter_shadow`, generated once per counter. It contains one 32-bit shadow register and one valid bit, with load, clear and consume inputs, and clear taking priority.
- The top level contains the FSM, index decode, the response mux and the output registers.

## Test plan
- Reset, then low read of idx 0 with counter0 = 0x0000_0001_FFFF_FFFF: `rd_valid_o` rises exactly one cycle after accept, with data 0xFFFF_FFFF. Counter0 then moves to 0x0000_0002_0000_0000 and idx 0 hi is read: data 0x0000_0001 from the shadow.
- High read of idx 2 with no prior low read, counter2 = 0xDEAD_BEEF_0000_0000: data 0xDEADBEEF. A second high read after a low read returns the shadow once, then the live value.
- Low read of idx 1 accepted in the same cycle as `wr_pulse_i[1]`: data is the pre-write low half. A following hi read returns the live high half, not a stale shadow.
- NumCounters = 3, read idx 3: `rd_err_o` = 1, data 0. Shadow_vld of all counters unchanged.
- CounterWidth = 40, counter = 0xFFFF_FFFF_FFFF_FFFF: low read gives 0xFFFF_FFFF, hi read gives 0x0000_00FF.
- `rst_i` pulsed in the RESP cycle: no `rd_valid_o` pulse follows. A hi read afterwards returns live data, since shadows are cleared. `rd_ready_o` is 0 during reset and 1 in the following cycle.
